// File: rtl/vita49_pack.sv
// rtl/vita49_pack.sv - VITA-49 IF-data transmit packetizer
//
// Frames a raw 32-bit sample stream into VITA-49 IF-data packets, one word
// per beat: header, stream ID, integer seconds, fractional seconds (hi, lo),
// then payload_words samples passed straight through. A source burst that
// ends early (S_AXIS_TLAST) is padded with zero words to the full length.
//
// Ports:
//   AXIS_ACLK, AXIS_ARESET        clock, synchronous active-high reset
//   S_AXIS_TDATA/TVALID/TLAST/TREADY  raw sample input stream
//   M_AXIS_TDATA/TVALID/TLAST/TREADY  packet output stream
//   enable                        allow new packets to start
//   stream_id, payload_words      per-packet fields, latched at start
//   timestamp_sec, timestamp_fsec free-running time, latched at start
//   status_clr                    clears the sticky status bits
//   status                        [0] busy, [1] short sticky, [2] zero-length
//                                 sticky, [19:16] packet count
//
// Build option: VITA49_PACK_TRAILER_EN appends a trailer word carrying the
// short-packet flag; TLAST then moves from the last payload word to it.

module vita49_pack (
  input  logic        AXIS_ACLK,
  input  logic        AXIS_ARESET,
  input  logic [31:0] S_AXIS_TDATA,
  input  logic        S_AXIS_TVALID,
  input  logic        S_AXIS_TLAST,
  output logic        S_AXIS_TREADY,
  output logic [31:0] M_AXIS_TDATA,
  output logic        M_AXIS_TVALID,
  output logic        M_AXIS_TLAST,
  input  logic        M_AXIS_TREADY,
  input  logic        enable,
  input  logic [31:0] stream_id,
  input  logic [15:0] payload_words,
  input  logic [31:0] timestamp_sec,
  input  logic [63:0] timestamp_fsec,
  input  logic        status_clr,
  output logic [31:0] status
);

  localparam logic [3:0] PKT_TYPE = 4'b0001;
  localparam logic [1:0] TSI      = 2'b01;
  localparam logic [1:0] TSF      = 2'b10;

`ifdef VITA49_PACK_TRAILER_EN
  localparam logic        T_BIT        = 1'b1;
  localparam logic [15:0] HDR_OVERHEAD = 16'd6;
`else
  localparam logic        T_BIT        = 1'b0;
  localparam logic [15:0] HDR_OVERHEAD = 16'd5;
`endif

  typedef enum logic [3:0] {
    ST_IDLE, ST_HDR, ST_SID, ST_TSI, ST_TSF_HI, ST_TSF_LO, ST_PAYLOAD, ST_PAD
`ifdef VITA49_PACK_TRAILER_EN
    , ST_TRAILER
`endif
  } state_t;

  // Where the packet goes after its last payload/pad word.
`ifdef VITA49_PACK_TRAILER_EN
  localparam state_t END_STATE = ST_TRAILER;
`else
  localparam state_t END_STATE = ST_IDLE;
`endif

  state_t      state, next_state;
  logic [15:0] plen_r;
  logic [31:0] sid_r;
  logic [31:0] sec_r;
  logic [63:0] fsec_r;
  logic [15:0] word_cnt;
  logic [3:0]  pkt_cnt;
  logic        short_sticky;
  logic        zero_sticky;
`ifdef VITA49_PACK_TRAILER_EN
  logic        short_this;
`endif

  logic        start;
  logic        zero_evt;
  logic        short_evt;
  logic        word_adv;
  logic        last_word;
  logic [15:0] pkt_size;
  logic [31:0] header;

  // plen_r is never zero inside a packet, so the subtraction cannot wrap.
  assign last_word = (word_cnt == plen_r - 16'd1);
  assign pkt_size  = plen_r + HDR_OVERHEAD;
  assign header    = {PKT_TYPE, 1'b0, T_BIT, 2'b00, TSI, TSF, pkt_cnt, pkt_size};
  assign status    = {12'h0, pkt_cnt, 13'h0, zero_sticky, short_sticky, state != ST_IDLE};

  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET) state <= ST_IDLE;
    else             state <= next_state;
  end

  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET) begin
      plen_r       <= 16'h0;
      sid_r        <= 32'h0;
      sec_r        <= 32'h0;
      fsec_r       <= 64'h0;
      word_cnt     <= 16'h0;
      pkt_cnt      <= 4'h0;
      short_sticky <= 1'b0;
      zero_sticky  <= 1'b0;
`ifdef VITA49_PACK_TRAILER_EN
      short_this   <= 1'b0;
`endif
    end else begin
      if (start) begin
        plen_r   <= payload_words;
        sid_r    <= stream_id;
        sec_r    <= timestamp_sec;
        fsec_r   <= timestamp_fsec;
        word_cnt <= 16'h0;
      end else if (word_adv) begin
        word_cnt <= word_cnt + 16'd1;
      end
      // TLAST is only ever raised on the final word, in either build.
      if (M_AXIS_TVALID && M_AXIS_TREADY && M_AXIS_TLAST)
        pkt_cnt <= pkt_cnt + 4'd1;
      if (short_evt)       short_sticky <= 1'b1;
      else if (status_clr) short_sticky <= 1'b0;
      if (zero_evt)        zero_sticky <= 1'b1;
      else if (status_clr) zero_sticky <= 1'b0;
`ifdef VITA49_PACK_TRAILER_EN
      if (start)          short_this <= 1'b0;
      else if (short_evt) short_this <= 1'b1;
`endif
    end
  end

  always_comb begin
    next_state    = state;
    M_AXIS_TDATA  = 32'h0;
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TLAST  = 1'b0;
    S_AXIS_TREADY = 1'b0;
    start         = 1'b0;
    zero_evt      = 1'b0;
    short_evt     = 1'b0;
    word_adv      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable && S_AXIS_TVALID) begin
          if (payload_words != 16'd0) begin
            start      = 1'b1;
            next_state = ST_HDR;
          end else begin
            zero_evt = 1'b1;
          end
        end
      end
      ST_HDR: begin
        M_AXIS_TDATA  = header;
        M_AXIS_TVALID = 1'b1;
        if (M_AXIS_TREADY) next_state = ST_SID;
      end
      ST_SID: begin
        M_AXIS_TDATA  = sid_r;
        M_AXIS_TVALID = 1'b1;
        if (M_AXIS_TREADY) next_state = ST_TSI;
      end
      ST_TSI: begin
        M_AXIS_TDATA  = sec_r;
        M_AXIS_TVALID = 1'b1;
        if (M_AXIS_TREADY) next_state = ST_TSF_HI;
      end
      ST_TSF_HI: begin
        M_AXIS_TDATA  = fsec_r[63:32];
        M_AXIS_TVALID = 1'b1;
        if (M_AXIS_TREADY) next_state = ST_TSF_LO;
      end
      ST_TSF_LO: begin
        M_AXIS_TDATA  = fsec_r[31:0];
        M_AXIS_TVALID = 1'b1;
        if (M_AXIS_TREADY) next_state = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        M_AXIS_TDATA  = S_AXIS_TDATA;
        M_AXIS_TVALID = S_AXIS_TVALID;
        S_AXIS_TREADY = M_AXIS_TREADY;
        M_AXIS_TLAST  = last_word && !T_BIT;
        if (S_AXIS_TVALID && M_AXIS_TREADY) begin
          word_adv = 1'b1;
          if (last_word) begin
            next_state = END_STATE;
          end else if (S_AXIS_TLAST) begin
            // Source burst ended early: pad the rest with zeros.
            short_evt  = 1'b1;
            next_state = ST_PAD;
          end
        end
      end
      ST_PAD: begin
        M_AXIS_TVALID = 1'b1;
        M_AXIS_TLAST  = last_word && !T_BIT;
        if (M_AXIS_TREADY) begin
          word_adv = 1'b1;
          if (last_word) next_state = END_STATE;
        end
      end
`ifdef VITA49_PACK_TRAILER_EN
      ST_TRAILER: begin
        M_AXIS_TDATA  = {31'h0, short_this};
        M_AXIS_TVALID = 1'b1;
        M_AXIS_TLAST  = 1'b1;
        if (M_AXIS_TREADY) next_state = ST_IDLE;
      end
`endif
      default: next_state = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_vita49_pack.sv
// tb/tb_vita49_pack.sv - self-checking bench for vita49_pack
module tb_vita49_pack;

`ifdef VITA49_PACK_TRAILER_EN
  localparam bit TRL = 1'b1;
`else
  localparam bit TRL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] S_AXIS_TDATA;
  logic        S_AXIS_TVALID;
  logic        S_AXIS_TLAST;
  logic        S_AXIS_TREADY;
  logic [31:0] M_AXIS_TDATA;
  logic        M_AXIS_TVALID;
  logic        M_AXIS_TLAST;
  logic        M_AXIS_TREADY;
  logic        enable;
  logic [31:0] stream_id;
  logic [15:0] payload_words;
  logic [31:0] timestamp_sec;
  logic [63:0] timestamp_fsec;
  logic        status_clr;
  logic [31:0] status;

  always #5 clk = ~clk;

  vita49_pack dut (
    .AXIS_ACLK      (clk),
    .AXIS_ARESET    (rst),
    .S_AXIS_TDATA   (S_AXIS_TDATA),
    .S_AXIS_TVALID  (S_AXIS_TVALID),
    .S_AXIS_TLAST   (S_AXIS_TLAST),
    .S_AXIS_TREADY  (S_AXIS_TREADY),
    .M_AXIS_TDATA   (M_AXIS_TDATA),
    .M_AXIS_TVALID  (M_AXIS_TVALID),
    .M_AXIS_TLAST   (M_AXIS_TLAST),
    .M_AXIS_TREADY  (M_AXIS_TREADY),
    .enable         (enable),
    .stream_id      (stream_id),
    .payload_words  (payload_words),
    .timestamp_sec  (timestamp_sec),
    .timestamp_fsec (timestamp_fsec),
    .status_clr     (status_clr),
    .status         (status)
  );

  logic [32:0] src_q[$];
  logic [32:0] exp_q[$];
  logic [32:0] exp_word;
  logic [33:0] held;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_cyc = 0;
  int exp_cnt = 0;
  bit mon_en = 0, gap_en = 0, rdy_rand = 0, src_flush = 0;
  bit gap_chk = 0, after_last = 0, stalled_prev = 0;
  bit s_fire = 0, m_fire = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] hdr(input int cnt, input int plen);
    logic [31:0] h;
    h = 32'h1060_0000 | (32'(cnt % 16) << 16) | 32'(plen + 5 + int'(TRL));
    if (TRL) h = h | 32'h0400_0000;
    return h;
  endfunction

  // Queue n_src samples and the full expected packet for them.
  task automatic send_pkt(input int plen, input int n_src, input bit src_last);
    logic [31:0] d;
    exp_q.push_back({1'b0, hdr(exp_cnt, plen)});
    exp_q.push_back({1'b0, stream_id});
    exp_q.push_back({1'b0, timestamp_sec});
    exp_q.push_back({1'b0, timestamp_fsec[63:32]});
    exp_q.push_back({1'b0, timestamp_fsec[31:0]});
    for (int i = 0; i < plen; i++) begin
      d = (i < n_src) ? $urandom : 32'h0;
      if (i < n_src) src_q.push_back({src_last && (i == n_src - 1), d});
      exp_q.push_back({(i == plen - 1) && !TRL, d});
    end
    if (TRL) exp_q.push_back({1'b1, 31'h0, n_src < plen});
    exp_cnt = (exp_cnt + 1) % 16;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    mon_en = 0;
    rst = 1;
    src_flush = 1;
    enable = 0;
    src_q.delete();
    exp_q.delete();
    step();
    chk("rst_tvalid", M_AXIS_TVALID, 0);
    chk("rst_tlast", M_AXIS_TLAST, 0);
    chk("rst_status", status, 0);
    rst = 0;
    src_flush = 0;
    exp_cnt = 0;
    after_last = 0;
    mon_en = 1;
  endtask

  // Output monitor / scoreboard, sampling mid-cycle.
  always @(negedge clk) begin
    cyc++;
    s_fire = S_AXIS_TVALID && S_AXIS_TREADY;
    m_fire = M_AXIS_TVALID && M_AXIS_TREADY;
    if (mon_en) begin
      if (stalled_prev)
        chk("stall_hold", {M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA}, held);
      if (gap_chk && after_last && M_AXIS_TVALID) begin
        chk("idle_gap", cyc - last_cyc, 2);
        after_last = 0;
      end
      if (m_fire) begin
        chk("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          exp_word = exp_q.pop_front();
          chk("beat", {M_AXIS_TLAST, M_AXIS_TDATA}, exp_word);
        end
        if (M_AXIS_TLAST) begin
          last_cyc = cyc;
          after_last = 1;
        end
      end
      stalled_prev = M_AXIS_TVALID && !M_AXIS_TREADY;
      held = {M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA};
    end else begin
      stalled_prev = 0;
    end
  end

  // Sample source (holds each beat until accepted) and sink ready.
  always @(posedge clk) begin
    #1;
    if (src_flush) begin
      S_AXIS_TVALID = 0;
    end else if (!S_AXIS_TVALID || s_fire) begin
      if (src_q.size() != 0 && !(gap_en && $urandom_range(0, 3) == 0)) begin
        {S_AXIS_TLAST, S_AXIS_TDATA} = src_q.pop_front();
        S_AXIS_TVALID = 1;
      end else begin
        S_AXIS_TVALID = 0;
      end
    end
    M_AXIS_TREADY = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  initial begin
    int n;
    rst = 1;
    S_AXIS_TDATA = 0;
    S_AXIS_TVALID = 0;
    S_AXIS_TLAST = 0;
    M_AXIS_TREADY = 1;
    enable = 0;
    stream_id = 0;
    payload_words = 0;
    timestamp_sec = 0;
    timestamp_fsec = 0;
    status_clr = 0;
    repeat (3) step();
    chk("reset_tvalid", M_AXIS_TVALID, 0);
    chk("reset_tdata", M_AXIS_TDATA, 0);
    chk("reset_tlast", M_AXIS_TLAST, 0);
    chk("reset_tready", S_AXIS_TREADY, 0);
    chk("reset_status", status, 0);
    rst = 0;
    mon_en = 1;

    // Basic packet, always ready; final-word source TLAST is ignored.
    stream_id = 32'hABCD_0001;
    timestamp_sec = 32'h10;
    timestamp_fsec = 64'h1_0000_0002;
    payload_words = 16'd4;
    chk("hdr_first", hdr(0, 4), TRL ? 32'h1460_000A : 32'h1060_0009);
    send_pkt(4, 4, 1);
    enable = 1;
    n = 0;
    while (!S_AXIS_TVALID && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("start_seen", S_AXIS_TVALID, 1);
    chk("idle_before_hdr", M_AXIS_TVALID, 0);
    @(negedge clk);
    chk("hdr_latency", M_AXIS_TVALID, 1);
    chk("busy", status[0], 1);
    // Fields must already be latched; later changes must not leak in.
    timestamp_sec = 32'hDEAD_BEEF;
    timestamp_fsec = '1;
    stream_id = 32'h0;
    step();
    drain(200);
    enable = 0;
    chk("idle_after1", status[0], 0);
    chk("pkt_cnt_after1", status[19:16], 1);

    // Random stalls on both sides.
    stream_id = 32'h5A5A_0002;
    timestamp_sec = 32'h1234;
    timestamp_fsec = 64'h0123_4567_89AB_CDEF;
    payload_words = 16'd6;
    gap_en = 1;
    rdy_rand = 1;
    for (int i = 0; i < 3; i++) send_pkt(6, 6, 0);
    enable = 1;
    drain(1000);
    enable = 0;
    gap_en = 0;
    rdy_rand = 0;
    step();
    chk("pkt_cnt_after_stall", status[19:16], 4);

    // Short burst padded with zeros.
    payload_words = 16'd8;
    send_pkt(8, 3, 1);
    enable = 1;
    drain(300);
    enable = 0;
    chk("short_sticky", status[1], 1);
    status_clr = 1;
    step();
    status_clr = 0;
    chk("short_clr", status[1], 0);

    // Zero-length request.
    payload_words = 16'd0;
    src_q.push_back({1'b0, 32'h1234_5678});
    enable = 1;
    repeat (10) step();
    chk("zero_sticky", status[2], 1);
    chk("zero_idle", status[0], 0);
    enable = 0;
    src_flush = 1;
    src_q.delete();
    step();
    src_flush = 0;
    status_clr = 1;
    step();
    status_clr = 0;
    chk("zero_clr", status[2], 0);

    // Reset in the middle of the payload, then a clean packet.
    payload_words = 16'd8;
    send_pkt(8, 8, 0);
    enable = 1;
    n = 0;
    while (exp_q.size() > 4 && n < 300) begin
      step();
      n++;
    end
    chk("in_payload", exp_q.size() <= 4, 1);
    do_reset();
    payload_words = 16'd4;
    send_pkt(4, 4, 0);
    enable = 1;
    drain(200);
    enable = 0;

    // 17 back-to-back packets: count field wraps, one idle cycle between.
    do_reset();
    payload_words = 16'd2;
    for (int i = 0; i < 17; i++) send_pkt(2, 2, 0);
    gap_chk = 1;
    enable = 1;
    drain(2000);
    gap_chk = 0;
    enable = 0;
    step();
    chk("pkt_cnt_wrap", status[19:16], 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vita49_pack.md
# vita49_pack

Transmit-side VITA-49 IF-data packetizer: takes a raw 32-bit sample stream and emits framed packets on an AXI-Stream master, one word per beat. Each packet carries a header, stream ID, integer-seconds and 64-bit fractional timestamps sampled at packet start, and a fixed-length payload. It sits between the sample source (DMA or DAC-side FIFO) and the transport, mirroring the existing unpack path.

## Interface
- PKT_TYPE, 4'b0001: header bits [31:28] (IF data with stream ID).
- TSI, 2'b01: header bits [23:22] (UTC).
- TSF, 2'b10: header bits [21:20] (real-time ps).
- AXIS_ACLK  in  1  sole clock.
- AXIS_ARESET  in  1  synchronous, active-high reset.
- S_AXIS_TDATA / S_AXIS_TVALID / S_AXIS_TLAST  in  32/1/1  raw samples; TLAST marks end of source burst.
- S_AXIS_TREADY  out  1.
- M_AXIS_TDATA / M_AXIS_TVALID / M_AXIS_TLAST  out  32/1/1  packet words; TLAST on final word.
- M_AXIS_TREADY  in  1.
- enable  in  1  start new packets while high.
- stream_id  in  32  stream ID word.
- payload_words  in  16  payload length in words, sampled at packet start.
- timestamp_sec / timestamp_fsec  in  32/64  free-running time.
- status_clr  in  1  clears sticky status bits.
- status  out  32  [0] busy, [1] short-packet sticky, [2] zero-length sticky, [19:16] current packet count, others 0.

## Operation
- States: IDLE, HDR, SID, TSI, TSF_HI, TSF_LO, PAYLOAD, PAD, (TRAILER).
- IDLE: S_AXIS_TREADY=0. Start when enable && S_AXIS_TVALID && payload_words!=0: latch payload_words, stream_id, timestamp_sec, timestamp_fsec; go HDR.
- enable && S_AXIS_TVALID && payload_words==0: set status[2]; stay IDLE.
- Header word: {PKT_TYPE, C=0, T, 2'b00, TSI, TSF, pkt_cnt[3:0], size[15:0]}, size = payload_words + 5 (+1 with trailer). T=0 without trailer.
- HDR->SID->TSI->TSF_HI->TSF_LO: emit header, stream_id, sec, fsec[63:32], fsec[31:0]; advance on M_AXIS_TVALID && M_AXIS_TREADY.
- PAYLOAD: pass-through; M_AXIS_TDATA=S_AXIS_TDATA, M_AXIS_TVALID=S_AXIS_TVALID, S_AXIS_TREADY=M_AXIS_TREADY; 16-bit word counter increments per accepted beat.
- Last payload word accepted -> IDLE (or TRAILER).
- S_AXIS_TLAST on a payload word before the count is reached: set status[1]; go PAD, emitting 32'h0 (S_AXIS_TREADY=0) until the count is reached. TLAST on the final word, or outside PAYLOAD, is ignored.
- pkt_cnt: 4-bit, increments on the final word of each packet, wraps 15->0.
- enable deasserted mid-packet: the packet completes; no new start.
- status[0]=1 in any state except IDLE. status_clr clears [2:1]; a set event in the same cycle wins.

## Timing
- Reset: state IDLE, M_AXIS_TVALID=0, M_AXIS_TDATA=0, M_AXIS_TLAST=0, S_AXIS_TREADY=0, pkt_cnt=0, status=0.
- Reset mid-packet: output is truncated; TVALID=0 the cycle after the reset edge; no TLAST is emitted.
- Header/pad/trailer words: registered and held stable while M_AXIS_TREADY=0.
- First header beat is valid one cycle after the start condition. Back-to-back packets: one IDLE cycle between the final word and the next header.
- Payload is zero latency (combinational pass-through); overall throughput is 1 word/cycle except in IDLE.
- Timestamp is the value present in the start cycle.

## Configuration
- VITA49_PACK_TRAILER_EN defined: header T=1 and size = payload_words + 6.
  - After the last payload/pad word, TRAILER emits {31'h0, short_this_pkt} with TLAST; TLAST is not set on the payload.
- Not defined: no TRAILER state, T=0, TLAST on the last payload word.

## Test plan
- payload_words=4, stream_id=0xABCD0001, sec=0x10, fsec=0x1_00000002, 4 samples, always ready -> 9 words: 0x10600009, 0xABCD0001, 0x10, 0x1, 0x2, samples; TLAST on word 9.
- 17 back-to-back packets -> header pkt_cnt field 0..15 then 0; one idle cycle between packets.
- Random M_AXIS_TREADY and S_AXIS_TVALID gaps -> data identical to the no-stall run; TDATA stable while stalled.
- payload_words=8, S_AXIS_TLAST on sample 3 -> 3 samples + 5 zero words, status[1]=1; status_clr -> 0.
- payload_words=0 with enable=1, TVALID=1 -> no output, status[2]=1.
- Reset asserted during PAYLOAD -> next cycle TVALID=0, pkt_cnt=0; next packet header correct. With VITA49_PACK_TRAILER_EN, repeat the first case -> size 0x000A, T bit 26 set, trailer 0 with TLAST.
